// File: rtl/smpl_iter_pkg.sv
// smpl_iter_pkg: shared widths, word/array types, FSM state encoding,
// subsample one-hot codes and the pitch-to-step decode used by smpl_iter.
package smpl_iter_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic [SIGFIG-1:0]          word_t;
  typedef word_t [VERTS-1:0][AXIS-1:0] tri_t;
  typedef word_t [COLORS-1:0]          color_t;
  // [0]=x, [1]=y
  typedef word_t [1:0]                 pt_t;
  // [0]=lower-left, [1]=upper-right
  typedef pt_t [1:0]                   box_t;

  typedef enum logic {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } state_e;

  localparam logic [3:0] SUB_1_0   = 4'b1000;
  localparam logic [3:0] SUB_0_5   = 4'b0100;
  localparam logic [3:0] SUB_0_25  = 4'b0010;
  localparam logic [3:0] SUB_0_125 = 4'b0001;

  // Steps carry one extra bit so position + step never wraps at the box edge.
  localparam logic signed [SIGFIG:0] STEP_1_0   = (SIGFIG+1)'(1 << RADIX);
  localparam logic signed [SIGFIG:0] STEP_0_5   = (SIGFIG+1)'(1 << (RADIX-1));
  localparam logic signed [SIGFIG:0] STEP_0_25  = (SIGFIG+1)'(1 << (RADIX-2));
  localparam logic signed [SIGFIG:0] STEP_0_125 = (SIGFIG+1)'(1 << (RADIX-3));

  // Any code that is not exactly one-hot falls back to full-pixel pitch.
  function automatic logic signed [SIGFIG:0] step_decode(input logic [3:0] sub);
    case (sub)
      SUB_0_5:   step_decode = STEP_0_5;
      SUB_0_25:  step_decode = STEP_0_25;
      SUB_0_125: step_decode = STEP_0_125;
      default:   step_decode = STEP_1_0;
    endcase
  endfunction

endpackage

// File: rtl/smpl_iter_if.sv
// smpl_iter_if: bbox-side inputs, downstream halt, and the R14 sample outputs.
// Optional SMPL_ITER_STATS_EN adds the sampCount_RnnnnU counter output.
//
// Handshake: a triangle is taken when validTri_R13H=1 and halt_RnnnnH_out=0
// at a rising edge; upstream must hold it while halt_RnnnnH_out=1. A sample is
// consumed at a rising edge where validSamp_R14H=1 and halt_RnnnnH=0; while
// halt_RnnnnH=1 the block holds the current sample unchanged.
interface smpl_iter_if;
  import smpl_iter_pkg::*;

  tri_t        tri_R13S;
  color_t      color_R13U;
  box_t        box_R13S;
  logic        validTri_R13H;
  logic [3:0]  subSample_RnnnnU;
  logic        halt_RnnnnH;
  logic        halt_RnnnnH_out;
  tri_t        tri_R14S;
  color_t      color_R14U;
  pt_t         sample_R14S;
  logic        validSamp_R14H;
`ifdef SMPL_ITER_STATS_EN
  logic [31:0] sampCount_RnnnnU;
`endif

  // Block side
  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnH,
    output halt_RnnnnH_out, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SMPL_ITER_STATS_EN
    , output sampCount_RnnnnU
`endif
  );

  // Driver side (bbox stage plus downstream halt source)
  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnH,
    input  halt_RnnnnH_out, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SMPL_ITER_STATS_EN
    , input  sampCount_RnnnnU
`endif
  );

endinterface

// File: rtl/smpl_step_gen.sv
// smpl_step_gen: combinational raster step. Given the current sample and the
// box, produce the next sample position or flag that the current one is last.
module smpl_step_gen
  import smpl_iter_pkg::*;
(
  input  word_t      x_i,
  input  word_t      y_i,
  input  word_t      ll_x_i,
  input  word_t      ur_x_i,
  input  word_t      ur_y_i,
  input  logic [3:0] sub_i,
  output word_t      next_x_o,
  output word_t      next_y_o,
  output logic       last_o
);

  logic signed [SIGFIG:0] step;
  logic signed [SIGFIG:0] x_inc;
  logic signed [SIGFIG:0] y_inc;
  logic signed [SIGFIG:0] ur_x_ext;
  logic signed [SIGFIG:0] ur_y_ext;

  // Advance along x; wrap to the next row; otherwise the walk is finished.
  always_comb begin
    step     = step_decode(sub_i);
    x_inc    = $signed({x_i[SIGFIG-1], x_i}) + step;
    y_inc    = $signed({y_i[SIGFIG-1], y_i}) + step;
    ur_x_ext = $signed({ur_x_i[SIGFIG-1], ur_x_i});
    ur_y_ext = $signed({ur_y_i[SIGFIG-1], ur_y_i});
    next_x_o = x_i;
    next_y_o = y_i;
    last_o   = 1'b0;
    if (x_inc <= ur_x_ext) begin
      next_x_o = x_inc[SIGFIG-1:0];
    end else if (y_inc <= ur_y_ext) begin
      next_x_o = ll_x_i;
      next_y_o = y_inc[SIGFIG-1:0];
    end else begin
      last_o = 1'b1;
    end
  end

endmodule

// File: rtl/smpl_iter.sv
// smpl_iter: walks one triangle's bounding box in raster order at the selected
// subsample pitch, one registered sample per unstalled cycle.
// Optional feature macro: SMPL_ITER_STATS_EN (adds sampCount_RnnnnU).
module smpl_iter
  import smpl_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  smpl_iter_if.slave  bus
);

  state_e state_q, state_d;
  tri_t   tri_q, tri_d;
  color_t color_q, color_d;
  word_t  ll_x_q, ll_x_d;
  word_t  ur_x_q, ur_x_d;
  word_t  ur_y_q, ur_y_d;
  word_t  x_q, x_d;
  word_t  y_q, y_d;
  logic   valid_q, valid_d;

  word_t  next_x;
  word_t  next_y;
  logic   last;

  smpl_step_gen u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .ll_x_i   (ll_x_q),
    .ur_x_i   (ur_x_q),
    .ur_y_i   (ur_y_q),
    .sub_i    (bus.subSample_RnnnnU),
    .next_x_o (next_x),
    .next_y_o (next_y),
    .last_o   (last)
  );

  // State and datapath registers; reset drops any triangle in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_STATE;
      tri_q   <= '0;
      color_q <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      ll_x_q  <= ll_x_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  // Next state: capture in WAIT, step or finish in TEST, freeze on halt.
  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    ll_x_d  = ll_x_q;
    ur_x_d  = ur_x_q;
    ur_y_d  = ur_y_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      WAIT_STATE: begin
        valid_d = 1'b0;
        if (bus.validTri_R13H) begin
          tri_d   = bus.tri_R13S;
          color_d = bus.color_R13U;
          ll_x_d  = bus.box_R13S[0][0];
          ur_x_d  = bus.box_R13S[1][0];
          ur_y_d  = bus.box_R13S[1][1];
          x_d     = bus.box_R13S[0][0];
          y_d     = bus.box_R13S[0][1];
          valid_d = 1'b1;
          state_d = TEST_STATE;
        end
      end
      TEST_STATE: begin
        if (!bus.halt_RnnnnH) begin
          if (last) begin
            valid_d = 1'b0;
            state_d = WAIT_STATE;
          end else begin
            x_d = next_x;
            y_d = next_y;
          end
        end
      end
      default: begin
        state_d = WAIT_STATE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers; upstream is stalled while iterating.
  always_comb begin
    bus.halt_RnnnnH_out = (state_q == TEST_STATE);
    bus.tri_R14S        = tri_q;
    bus.color_R14U      = color_q;
    bus.sample_R14S[0]  = x_q;
    bus.sample_R14S[1]  = y_q;
    bus.validSamp_R14H  = valid_q;
  end

`ifdef SMPL_ITER_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of samples that left the block unstalled.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !bus.halt_RnnnnH && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Sample counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter output.
  always_comb begin
    bus.sampCount_RnnnnU = cnt_q;
  end
`endif

endmodule
